// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared defaults, buffer entry type and PC helper for the fetch stage
package fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_ADDR      = 32'h0000_0000;
    localparam int          DEF_FIFO_DEPTH      = 4;
    localparam int          DEF_MAX_OUTSTANDING = 2;
    localparam logic [31:0] NOP_WORD            = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer of {pc,inst} entries with sync clear and simultaneous push/pop
module fetch_fifo import fetch_unit_pkg::*; #(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         empty,
    output logic         full,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra bit so full and empty are distinguishable
    assign count   = wr_ptr - rd_ptr;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + CW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + CW'(1) : rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential-PC fetch over a ready/valid memory port with redirect flush
module fetch_unit import fetch_unit_pkg::*; #(
    parameter logic [31:0] RESET_ADDR      = DEF_RESET_ADDR,
    parameter int          FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int          MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc
);

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   redirect_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [OW-1:0] in_flight;
    logic [CW-1:0] fifo_count;
    logic          req_fire;
    logic          rsp_fire;
    logic          dropping;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    int            credit_used;
    fetch_entry_t  head;

    // Stale in-flight words will be discarded, so they hold no buffer credit
    assign credit_used     = int'(fifo_count) + int'(outstanding) - int'(drop_cnt);
    assign o_mem_req_valid = !i_rst && int'(outstanding) < MAX_OUTSTANDING && credit_used < FIFO_DEPTH;
    assign o_mem_req_addr  = fetch_pc;
    assign req_fire        = o_mem_req_valid && i_mem_req_ready;
    assign rsp_fire        = i_mem_rsp_valid && !i_rst;
    assign dropping        = drop_cnt != '0;
    assign push            = rsp_fire && !dropping && !i_redirect_valid;
    assign pop             = o_inst_valid && i_inst_ready && !i_redirect_valid;
    assign in_flight       = outstanding + OW'(req_fire) - OW'(rsp_fire);
    assign redirect_pc     = word_align(i_redirect_pc);
    assign o_inst_valid    = !fifo_empty;
    assign o_inst          = fifo_empty ? NOP_WORD : head.inst;
    assign o_inst_pc       = head.pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_ADDR;
            rsp_pc      <= RESET_ADDR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= in_flight;
            fetch_pc    <= i_redirect_valid ? redirect_pc : req_fire ? fetch_pc + 32'd4 : fetch_pc;
            rsp_pc      <= i_redirect_valid ? redirect_pc : push ? rsp_pc + 32'd4 : rsp_pc;
            drop_cnt    <= i_redirect_valid ? in_flight :
                           (rsp_fire && dropping) ? drop_cnt - OW'(1) : drop_cnt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_mem_rsp_valid && outstanding == '0));
            assert (!(push && fifo_full && !pop));
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (i_redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ('{pc: rsp_pc, inst: i_mem_rsp_data}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule
